// File: rtl/dmem_pkg.sv
// Shared types and helpers for the clocked data memory.
// Imported by dmem_sync and dmem_array.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int LAT_MAX = 4;
  localparam int CNT_W   = 3;

  function automatic int off_w(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage with byte-lane writes and a registered read port.
// The holding register is what the response channel presents.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cap,
  input  logic                rd_en,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] be,
  output logic [DATA_W-1:0]   rdata
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int NB    = DATA_W / 8;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;

  // Stores and errors capture zero so the response reads 0.
  always_comb begin
    rdata_d = rdata_q;
    if (cap) begin
      rdata_d = rd_en ? mem_q[addr] : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) begin
          mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_sync.sv
// Clocked data memory with valid/ready request and response.
// One request in flight; response after LATENCY cycles.
module dmem_sync
  import dmem_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 9,
  parameter int LATENCY = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [31:0]         req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err
);

  localparam int OFF_W = off_w(DATA_W);
  localparam int HI    = ADDR_W + OFF_W;

  localparam logic [31:0] OFF_MASK =
    (32'd1 << OFF_W) - 32'd1;

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((LATENCY > 1) ? LATENCY - 2 : 0);

  if (LATENCY < 1 || LATENCY > LAT_MAX) begin : g_bad_lat
    $fatal(1, "dmem_sync: LATENCY out of range");
  end

  if (DATA_W % 8 != 0) begin : g_bad_w8
    $fatal(1, "dmem_sync: DATA_W not byte multiple");
  end

  if (DATA_W < 8 || DATA_W > 64 ||
      (DATA_W & (DATA_W - 1)) != 0) begin : g_bad_wp
    $fatal(1, "dmem_sync: DATA_W not 8..64 pow2");
  end

  if (HI > 32) begin : g_bad_aw
    $fatal(1, "dmem_sync: ADDR_W too wide");
  end

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             err_q;
  logic             err_d;

  logic              accept;
  logic              mis;
  logic              oor;
  logic              bad;
  logic [ADDR_W-1:0] idx;
  logic [31:0]       hi_bits;

  assign hi_bits = req_addr >> HI;
  assign mis     = |(req_addr & OFF_MASK);
  assign oor     = |hi_bits;
  assign bad     = mis | oor;
  assign idx     = req_addr[HI-1:OFF_W];

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign accept    = req_valid & req_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          err_d   = bad;
          cnt_d   = '0;
          state_d = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  dmem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .cap   (accept),
    .rd_en (accept & ~req_write & ~bad),
    .wr_en (accept & req_write & ~bad),
    .addr  (idx),
    .wdata (req_wdata),
    .be    (req_be),
    .rdata (rsp_rdata)
  );

  assign rsp_err = err_q;

endmodule
